mem_access_stage: RTL and testbench

// RV32I memory stage; consumes the execute-stage output register (flags, alu_out, mem_wr_data, mem_width, rd_addr).

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
// Single outstanding req/ack transfer; dmem_ack is a one-cycle completion pulse.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I memory stage: issues loads/stores on the data bus, extracts/extends load data
// and registers the write-back bundle, stalling upstream while a transfer is pending.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 stage_flag_in,
    input  logic [1:0]                 mem_to_reg_in,
    input  logic [3:0]                 mem_width_in,
    input  logic [31:0]                alu_out_in,
    input  logic [31:0]                mem_wr_data_in,
    input  logic [4:0]                 rd_addr_in,
    mem_access_stage_if.master         dmem,
    output logic                       mem_stall,
    output logic                       wb_rd_en,
    output logic [1:0]                 wb_mem_to_reg,
    output logic [4:0]                 wb_rd_addr,
    output logic [31:0]                wb_alu_result,
    output logic [31:0]                wb_load_data,
    output logic                       mem_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          op_load_q, op_load_d;
    logic          op_rd_en_q, op_rd_en_d;
    logic [2:0]    op_width_q, op_width_d;
    logic [1:0]    op_lane_q, op_lane_d;
    logic [31:0]   op_alu_q, op_alu_d;
    logic [4:0]    op_rd_addr_q, op_rd_addr_d;
    logic [1:0]    op_m2r_q, op_m2r_d;

    logic          wb_rd_en_d;
    logic [1:0]    wb_m2r_d;
    logic [4:0]    wb_rd_addr_d;
    logic [31:0]   wb_alu_d;
    logic [31:0]   wb_load_d;
    logic          mem_err_d;

    logic          rd_flag, wr_flag, rd_en_flag, is_mem;
    logic [2:0]    funct3;
    logic [1:0]    lane;
    logic          misaligned;
    logic [3:0]    store_be;
    logic [31:0]   store_wdata;
    logic          timeout_hit;
    logic          unused_inputs;

    // branch_en is consumed upstream and width bit 3 carries no meaning here
    assign unused_inputs = ^{stage_flag_in[1], mem_width_in[3]};

    assign rd_flag    = stage_flag_in[3];
    assign wr_flag    = stage_flag_in[2];
    assign rd_en_flag = stage_flag_in[0];
    assign is_mem     = rd_flag | wr_flag;
    assign funct3     = mem_width_in[2:0];
    assign lane       = alu_out_in[1:0];

    always_comb begin
        misaligned  = 1'b0;
        store_be    = 4'b1111;
        store_wdata = mem_wr_data_in;
        case (funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << lane;
                store_wdata = {4{mem_wr_data_in[7:0]}};
            end
            2'b01: begin
                misaligned  = lane[0];
                store_be    = 4'b0011 << lane;
                store_wdata = {2{mem_wr_data_in[15:0]}};
            end
            default: begin
                misaligned  = (lane != 2'b00);
            end
        endcase
    end

    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [2:0]  width,
                                                 input logic [1:0]  sel);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = rdata[{sel, 3'b000} +: 8];
        half_v = rdata[{sel[1], 4'b0000} +: 16];
        case (width)
            3'b000:  extract_load = {{24{byte_v[7]}}, byte_v};
            3'b100:  extract_load = {24'h0, byte_v};
            3'b001:  extract_load = {{16{half_v[15]}}, half_v};
            3'b101:  extract_load = {16'h0, half_v};
            default: extract_load = rdata;
        endcase
    endfunction

    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    // Next-state and next-output logic; a coincident ack always beats the timeout
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        op_load_d    = op_load_q;
        op_rd_en_d   = op_rd_en_q;
        op_width_d   = op_width_q;
        op_lane_d    = op_lane_q;
        op_alu_d     = op_alu_q;
        op_rd_addr_d = op_rd_addr_q;
        op_m2r_d     = op_m2r_q;
        wb_rd_en_d   = 1'b0;
        wb_m2r_d     = wb_mem_to_reg;
        wb_rd_addr_d = wb_rd_addr;
        wb_alu_d     = wb_alu_result;
        wb_load_d    = wb_load_data;
        mem_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    wb_rd_en_d   = rd_en_flag;
                    wb_m2r_d     = mem_to_reg_in;
                    wb_rd_addr_d = rd_addr_in;
                    wb_alu_d     = alu_out_in;
                    wb_load_d    = 32'h0;
                end else if (misaligned) begin
                    mem_err_d    = 1'b1;
                    wb_m2r_d     = mem_to_reg_in;
                    wb_rd_addr_d = rd_addr_in;
                    wb_alu_d     = alu_out_in;
                    wb_load_d    = 32'h0;
                end else begin
                    state_d      = BUSY;
                    cnt_d        = '0;
                    req_d        = 1'b1;
                    we_d         = wr_flag;
                    addr_d       = {alu_out_in[31:2], 2'b00};
                    be_d         = store_be;
                    wdata_d      = store_wdata;
                    op_load_d    = !wr_flag;
                    op_rd_en_d   = rd_en_flag;
                    op_width_d   = funct3;
                    op_lane_d    = lane;
                    op_alu_d     = alu_out_in;
                    op_rd_addr_d = rd_addr_in;
                    op_m2r_d     = mem_to_reg_in;
                end
            end
            BUSY: begin
                if (dmem.dmem_ack) begin
                    state_d      = IDLE;
                    req_d        = 1'b0;
                    wb_rd_en_d   = op_load_q & op_rd_en_q;
                    wb_m2r_d     = op_m2r_q;
                    wb_rd_addr_d = op_rd_addr_q;
                    wb_alu_d     = op_alu_q;
                    wb_load_d    = op_load_q ? extract_load(dmem.dmem_rdata, op_width_q, op_lane_q)
                                             : 32'h0;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 32'h0;
            be_q          <= 4'h0;
            wdata_q       <= 32'h0;
            op_load_q     <= 1'b0;
            op_rd_en_q    <= 1'b0;
            op_width_q    <= 3'h0;
            op_lane_q     <= 2'h0;
            op_alu_q      <= 32'h0;
            op_rd_addr_q  <= 5'h0;
            op_m2r_q      <= 2'h0;
            wb_rd_en      <= 1'b0;
            wb_mem_to_reg <= 2'h0;
            wb_rd_addr    <= 5'h0;
            wb_alu_result <= 32'h0;
            wb_load_data  <= 32'h0;
            mem_err       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            op_load_q     <= op_load_d;
            op_rd_en_q    <= op_rd_en_d;
            op_width_q    <= op_width_d;
            op_lane_q     <= op_lane_d;
            op_alu_q      <= op_alu_d;
            op_rd_addr_q  <= op_rd_addr_d;
            op_m2r_q      <= op_m2r_d;
            wb_rd_en      <= wb_rd_en_d;
            wb_mem_to_reg <= wb_m2r_d;
            wb_rd_addr    <= wb_rd_addr_d;
            wb_alu_result <= wb_alu_d;
            wb_load_data  <= wb_load_d;
            mem_err       <= mem_err_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign mem_stall       = (state_q == BUSY) && !dmem.dmem_ack;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment, timeout and reset abort,
// with hand-computed expected values.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  stage_flag_in;
    logic [1:0]  mem_to_reg_in;
    logic [3:0]  mem_width_in;
    logic [31:0] alu_out_in;
    logic [31:0] mem_wr_data_in;
    logic [4:0]  rd_addr_in;
    logic        mem_stall;
    logic        wb_rd_en;
    logic [1:0]  wb_mem_to_reg;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_load_data;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .stage_flag_in  (stage_flag_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .mem_width_in   (mem_width_in),
        .alu_out_in     (alu_out_in),
        .mem_wr_data_in (mem_wr_data_in),
        .rd_addr_in     (rd_addr_in),
        .dmem           (dmem_bus.master),
        .mem_stall      (mem_stall),
        .wb_rd_en       (wb_rd_en),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_rd_addr     (wb_rd_addr),
        .wb_alu_result  (wb_alu_result),
        .wb_load_data   (wb_load_data),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] flags, input logic [1:0] m2r, input logic [2:0] width,
                                 input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] rd);
        stage_flag_in  = flags;
        mem_to_reg_in  = m2r;
        mem_width_in   = {1'b0, width};
        alu_out_in     = alu;
        mem_wr_data_in = wdata;
        rd_addr_in     = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a load, hold off ack for wait_cycles busy cycles, then complete and check the result
    task automatic runLoad(input string tag, input logic [2:0] width, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] expected, input int wait_cycles);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        applyStimulus(4'b1001, 2'b01, width, addr, 32'h0, 5'd7);
        step();
        checkOutput({tag, " req"}, {31'h0, dmem_bus.dmem_req}, 32'h1);
        checkOutput({tag, " addr"}, dmem_bus.dmem_addr, word_addr);
        checkOutput({tag, " we"}, {31'h0, dmem_bus.dmem_we}, 32'h0);
        applyStimulus(4'b0001, 2'b00, 3'b000, 32'hDEAD_0000, 32'h0, 5'd9);
        for (int i = 0; i < wait_cycles; i++) begin
            checkOutput({tag, " stall"}, {31'h0, mem_stall}, 32'h1);
            checkOutput({tag, " bubble"}, {31'h0, wb_rd_en}, 32'h0);
            step();
        end
        checkOutput({tag, " req held"}, {31'h0, dmem_bus.dmem_req}, 32'h1);
        dmem_bus.dmem_rdata = rdata;
        dmem_bus.dmem_ack   = 1'b1;
        #1;
        checkOutput({tag, " stall on ack"}, {31'h0, mem_stall}, 32'h0);
        step();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        applyStimulus(4'b0000, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        checkOutput({tag, " req drop"}, {31'h0, dmem_bus.dmem_req}, 32'h0);
        checkOutput({tag, " data"}, wb_load_data, expected);
        checkOutput({tag, " wb_rd_en"}, {31'h0, wb_rd_en}, 32'h1);
        checkOutput({tag, " wb_rd_addr"}, {27'h0, wb_rd_addr}, 32'd7);
        checkOutput({tag, " wb_alu"}, wb_alu_result, addr);
        checkOutput({tag, " wb_m2r"}, {30'h0, wb_mem_to_reg}, 32'h1);
    endtask

    // Issue a store with ack on the first busy cycle; both rd and wr flags set to show rd is ignored
    task automatic runStore(input string tag, input logic [2:0] width, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        applyStimulus(4'b1101, 2'b00, width, addr, data, 5'd4);
        step();
        applyStimulus(4'b0000, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        checkOutput({tag, " req"}, {31'h0, dmem_bus.dmem_req}, 32'h1);
        checkOutput({tag, " we"}, {31'h0, dmem_bus.dmem_we}, 32'h1);
        checkOutput({tag, " addr"}, dmem_bus.dmem_addr, word_addr);
        checkOutput({tag, " be"}, {28'h0, dmem_bus.dmem_be}, {28'h0, exp_be});
        checkOutput({tag, " wdata"}, dmem_bus.dmem_wdata, exp_wdata);
        dmem_bus.dmem_ack = 1'b1;
        step();
        dmem_bus.dmem_ack = 1'b0;
        checkOutput({tag, " req drop"}, {31'h0, dmem_bus.dmem_req}, 32'h0);
        checkOutput({tag, " wb_rd_en"}, {31'h0, wb_rd_en}, 32'h0);
        checkOutput({tag, " wb_load"}, wb_load_data, 32'h0);
    endtask

    int req_cycles;

    initial begin
        reset               = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        dmem_bus.dmem_ack   = 1'b0;
        applyStimulus(4'b0000, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        #1;
        checkOutput("reset req", {31'h0, dmem_bus.dmem_req}, 32'h0);
        step();
        step();
        checkOutput("reset wb_rd_en", {31'h0, wb_rd_en}, 32'h0);
        checkOutput("reset wb_alu", wb_alu_result, 32'h0);
        checkOutput("reset mem_err", {31'h0, mem_err}, 32'h0);
        checkOutput("reset stall", {31'h0, mem_stall}, 32'h0);
        reset = 1'b1;

        // ALU pass-through
        applyStimulus(4'b0001, 2'b10, 3'b000, 32'h55, 32'h0, 5'd5);
        step();
        checkOutput("add wb_alu", wb_alu_result, 32'h55);
        checkOutput("add wb_rd_en", {31'h0, wb_rd_en}, 32'h1);
        checkOutput("add wb_rd_addr", {27'h0, wb_rd_addr}, 32'd5);
        checkOutput("add wb_m2r", {30'h0, wb_mem_to_reg}, 32'h2);
        checkOutput("add wb_load", wb_load_data, 32'h0);
        checkOutput("add no req", {31'h0, dmem_bus.dmem_req}, 32'h0);

        // Loads, issued back to back
        runLoad("lb", 3'b000, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80, 2);
        runLoad("lhu", 3'b101, 32'h0000_2002, 32'hBEEF_1234, 32'h0000_BEEF, 0);
        runLoad("lh", 3'b001, 32'h0000_2002, 32'hBEEF_1234, 32'hFFFF_BEEF, 0);
        runLoad("lbu", 3'b100, 32'h0000_5001, 32'h0000_9A00, 32'h0000_009A, 1);
        runLoad("lh lo", 3'b001, 32'h0000_5000, 32'h0000_7FFE, 32'h0000_7FFE, 0);
        runLoad("lw", 3'b010, 32'h0000_6000, 32'hCAFE_BABE, 32'hCAFE_BABE, 0);

        // Stores
        runStore("sb", 3'b000, 32'h0000_3001, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB);
        runStore("sh", 3'b001, 32'h0000_3002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        runStore("sw", 3'b010, 32'h0000_3004, 32'h0102_0304, 4'b1111, 32'h0102_0304);

        // Misaligned accesses
        applyStimulus(4'b1001, 2'b01, 3'b010, 32'h0000_4002, 32'h0, 5'd6);
        step();
        checkOutput("lw misalign req", {31'h0, dmem_bus.dmem_req}, 32'h0);
        checkOutput("lw misalign err", {31'h0, mem_err}, 32'h1);
        checkOutput("lw misalign rd_en", {31'h0, wb_rd_en}, 32'h0);
        checkOutput("lw misalign stall", {31'h0, mem_stall}, 32'h0);
        applyStimulus(4'b0001, 2'b00, 3'b000, 32'h55, 32'h0, 5'd5);
        step();
        checkOutput("after misalign alu", wb_alu_result, 32'h55);
        checkOutput("after misalign err", {31'h0, mem_err}, 32'h0);
        checkOutput("after misalign rd_en", {31'h0, wb_rd_en}, 32'h1);
        applyStimulus(4'b0100, 2'b00, 3'b001, 32'h0000_4001, 32'h0, 5'd0);
        step();
        checkOutput("sh misalign req", {31'h0, dmem_bus.dmem_req}, 32'h0);
        checkOutput("sh misalign err", {31'h0, mem_err}, 32'h1);

        // Timeout with no ack
        applyStimulus(4'b1001, 2'b01, 3'b010, 32'h0000_7000, 32'h0, 5'd8);
        step();
        applyStimulus(4'b0000, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (dmem_bus.dmem_req) req_cycles++;
            if (i == 4) begin
                checkOutput("timeout err", {31'h0, mem_err}, 32'h1);
                checkOutput("timeout stall", {31'h0, mem_stall}, 32'h0);
                checkOutput("timeout rd_en", {31'h0, wb_rd_en}, 32'h0);
            end
            if (i == 5) checkOutput("timeout err pulse", {31'h0, mem_err}, 32'h0);
            step();
        end
        checkOutput("timeout req cycles", req_cycles, 32'd4);
        applyStimulus(4'b0001, 2'b00, 3'b000, 32'h66, 32'h0, 5'd2);
        step();
        checkOutput("post timeout alu", wb_alu_result, 32'h66);
        checkOutput("post timeout rd_en", {31'h0, wb_rd_en}, 32'h1);

        // Ack on the expiry cycle completes normally
        applyStimulus(4'b1001, 2'b01, 3'b010, 32'h0000_9000, 32'h0, 5'd3);
        step();
        applyStimulus(4'b0000, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        step();
        step();
        step();
        checkOutput("expiry req", {31'h0, dmem_bus.dmem_req}, 32'h1);
        dmem_bus.dmem_rdata = 32'h1357_9BDF;
        dmem_bus.dmem_ack   = 1'b1;
        step();
        dmem_bus.dmem_ack   = 1'b0;
        checkOutput("expiry err", {31'h0, mem_err}, 32'h0);
        checkOutput("expiry data", wb_load_data, 32'h1357_9BDF);
        checkOutput("expiry rd_en", {31'h0, wb_rd_en}, 32'h1);

        // Reset while busy, then a stray late ack
        applyStimulus(4'b0001, 2'b00, 3'b000, 32'h77, 32'h0, 5'd3);
        step();
        applyStimulus(4'b1001, 2'b01, 3'b010, 32'h0000_8000, 32'h0, 5'd3);
        step();
        checkOutput("rst busy req", {31'h0, dmem_bus.dmem_req}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("rst async req", {31'h0, dmem_bus.dmem_req}, 32'h0);
        checkOutput("rst async alu", wb_alu_result, 32'h0);
        checkOutput("rst async rd_addr", {27'h0, wb_rd_addr}, 32'h0);
        checkOutput("rst async stall", {31'h0, mem_stall}, 32'h0);
        applyStimulus(4'b0000, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        #1;
        reset = 1'b1;
        dmem_bus.dmem_rdata = 32'hFFFF_FFFF;
        dmem_bus.dmem_ack   = 1'b1;
        #1;
        checkOutput("late ack stall", {31'h0, mem_stall}, 32'h0);
        step();
        dmem_bus.dmem_ack = 1'b0;
        checkOutput("late ack req", {31'h0, dmem_bus.dmem_req}, 32'h0);
        checkOutput("late ack load", wb_load_data, 32'h0);
        checkOutput("late ack rd_en", {31'h0, wb_rd_en}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
